mux_arbiter_8: RTL and testbench
================================

MUX_ARBITER_8 -- requirements
Module: mux_arbiter_8

Interface
REQ-001 Parameter: WIDTH, 32, data width of each requester lane and of the output.
REQ-002 Parameter: BURST_MAX, 4, maximum beats per grant before forced release (legal range 1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req  input  8  per-requester request; bit i held high while requester i has data.
REQ-006 Port: data_in  input  8*WIDTH  flat requester data; lane i = bits [i*WIDTH +: WIDTH].
REQ-007 Port: out_ready  input  1  downstream accepts a beat this cycle.
REQ-008 Port: out_valid  output  1  beat present on out_data.
REQ-009 Port: out_data  output  WIDTH  data of granted lane, 8:1 selected by sel.
REQ-010 Port: grant  output  8  one-hot owner of the datapath; zero when idle.
REQ-011 Port: sel  output  3  binary index of current owner; drives the 8:1 select.
REQ-012 Port: ack  output  8  one-cycle pulse on bit i when a beat of requester i is consumed.
REQ-013 Port: busy  output  1  high while in GRANT state.

Function
REQ-014 Two states, IDLE and GRANT; grant, sel and busy SHALL be registered.
REQ-015 IDLE, req == 0: remain IDLE, grant = 0, out_valid = 0.
REQ-016 IDLE, req != 0: winner = first set bit scanning upward from (last_winner+1) mod 8, wrapping at 7->0; next cycle enter GRANT with grant = one-hot(winner), sel = winner, beat_cnt = 0.
REQ-017 Arbitration latency SHALL be exactly one cycle from req sampled in IDLE to grant visible.
REQ-018 GRANT: out_valid = req[sel] (combinational); out_data = data_in lane sel at all times, including IDLE (sel holds last value).
REQ-019 Beat transfer = out_valid && out_ready in GRANT; ack[sel] SHALL pulse that same cycle; all other ack bits 0.
REQ-020 On each transfer beat_cnt SHALL increment by 1 (8-bit counter, never wraps while in GRANT).
REQ-021 Exit GRANT -> IDLE at the next edge when: req[sel] == 0 (no transfer that cycle), or a transfer occurs with beat_cnt == BURST_MAX-1.
REQ-022 On exit, last_winner SHALL be set to sel; grant cleared to 0; busy cleared.
REQ-023 One idle bubble cycle SHALL separate consecutive grants (IDLE always visited).
REQ-024 Requests from non-owners during GRANT SHALL be ignored until the next IDLE evaluation; no pre-emption.
REQ-025 out_ready held low in GRANT: owner keeps grant indefinitely while req[sel] stays high; no beat counted.
REQ-026 Owner dropping req with out_ready high in same cycle: no transfer, no ack, exit per REQ-021.
REQ-027 grant SHALL never have more than one bit set; sel SHALL equal the index of the set bit whenever grant != 0.

Reset
REQ-028 rst_n low at a rising edge SHALL force: state IDLE, grant = 0, sel = 0, busy = 0, beat_cnt = 0, last_winner = 7 (requester 0 first priority).
REQ-029 With rst_n low, out_valid = 0 and ack = 0 regardless of req/out_ready.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no ack in the reset cycle; arbitration restarts from requester 0 after release.

Verification
REQ-031 After reset, req = 8'b1000_0001, out_ready = 1 -> grant = 8'h01 one cycle later, sel = 0, 4 acks on bit 0 then IDLE, then grant = 8'h80.
REQ-032 All req = 8'hFF held, out_ready = 1, BURST_MAX = 4 -> grants rotate 0,1,2,...,7,0 with exactly 4 beats each and one idle cycle between.
REQ-033 Grant to 3, out_ready low for 10 cycles -> grant = 8'h08 stays, ack = 0, beat_cnt stays 0; then ready high -> 4 beats of data_in lane 3 on out_data.
REQ-034 Grant to 5, req[5] drops after 2 beats -> exactly 2 ack[5] pulses, IDLE next edge, last_winner = 5, next pending requester 6 wins over 2.
REQ-035 rst_n low during beat 2 of requester 4 -> grant = 0, busy = 0 next edge; after release with req = 8'h30 -> grant = 8'h10 (requester 4, scan from 0).
REQ-036 Every cycle: assert grant one-hot-or-zero, ack subset of grant, out_data == data_in lane sel.

Source files
------------

// File: rtl/mux_arbiter_8.sv
// Round-robin arbiter for eight requester lanes with burst-limited grants.
// The owner's lane is steered 8:1 onto the output by the registered sel.
module mux_arbiter_8 #(
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] data_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [7:0]         grant,
  output logic [2:0]         sel,
  output logic [7:0]         ack,
  output logic               busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [2:0] last_winner_q, last_winner_d;

  logic       xfer;
  logic       found;
  logic [2:0] win;

  assign out_valid = rst_n && (state_q == GRANT) && req[sel_q];
  assign xfer      = out_valid && out_ready;
  assign ack       = xfer ? (8'b1 << sel_q) : 8'b0;
  assign out_data  = data_in[sel_q*WIDTH +: WIDTH];
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

  // Rotating priority: first request at or after last_winner+1.
  always_comb begin
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = last_winner_q + 3'(k + 1);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    busy_d        = busy_q;
    beat_cnt_d    = beat_cnt_q;
    last_winner_d = last_winner_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          state_d    = GRANT;
          grant_d    = 8'b1 << win;
          sel_d      = win;
          busy_d     = 1'b1;
          beat_cnt_d = 8'd0;
        end
      end
      (state_q == GRANT): begin
        if (!req[sel_q] ||
            (xfer && beat_cnt_q == LAST_BEAT)) begin
          state_d       = IDLE;
          grant_d       = 8'd0;
          busy_d        = 1'b0;
          last_winner_d = sel_q;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 8'd0;
      sel_q         <= 3'd0;
      busy_q        <= 1'b0;
      beat_cnt_q    <= 8'd0;
      last_winner_q <= 3'd7;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      beat_cnt_q    <= beat_cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_8.sv
// Random and directed stimulus for mux_arbiter_8 against a
// transaction-level round-robin reference model.
module tb_mux_arbiter_8;
  localparam int W  = 32;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] data_in;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [7:0]     grant;
  logic [2:0]     sel;
  logic [7:0]     ack;
  logic           busy;

  mux_arbiter_8 #(.WIDTH(W), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .sel       (sel),
    .ack       (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: who owns the bus, beats delivered, last winner.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_last;
  int grants_seen;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) data_in[i*W +: W] = $urandom;
  endtask

  task automatic check_outputs();
    logic [7:0] eg, ea;
    logic ev;
    eg = m_busy ? (8'b1 << m_owner) : 8'd0;
    ev = rst_n && m_busy && req[m_owner];
    ea = (ev && out_ready) ? eg : 8'd0;
    chk("grant", grant, eg);
    chk("sel", sel, m_owner);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, ev);
    chk("ack", ack, ea);
    chk("out_data", out_data, data_in[m_owner*W +: W]);
    chk("onehot0", $onehot0(grant), 1);
    chk("ack_in_grant", ack & ~grant, 0);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_busy  = 0;
      m_owner = 0;
      m_beats = 0;
      m_last  = 7;
    end else if (!m_busy) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (req[c]) begin
          m_busy  = 1;
          m_owner = c;
          m_beats = 0;
          grants_seen++;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == BM) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rand_data();
  endtask

  initial begin
    grants_seen = 0;
    rst_n     = 1'b0;
    req       = 8'd0;
    out_ready = 1'b0;
    rand_data();
    repeat (2) @(posedge clk);
    m_busy  = 0;
    m_owner = 0;
    m_beats = 0;
    m_last  = 7;
    @(negedge clk);
    req = 8'hFF;
    out_ready = 1'b1;
    cycle();
    chk("rst_grant", grant, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 3'd0);

    // Requesters 0 and 7: 0 first, four beats, bubble, then 7.
    rst_n = 1'b1;
    req   = 8'h81;
    cycle();
    chk("first_grant", grant, 8'h01);
    repeat (4) cycle();
    chk("bubble", grant, 8'h00);
    cycle();
    chk("second_grant", grant, 8'h80);
    repeat (6) cycle();

    // Full rotation under saturation.
    req = 8'hFF;
    repeat (60) cycle();

    // Stall with ready low, then release.
    out_ready = 1'b0;
    repeat (10) cycle();
    out_ready = 1'b1;
    repeat (10) cycle();

    // Randomised: sticky requests, mostly-ready sink, rare resets.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    chk("grants_happened", grants_seen > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
